// File: rtl/conv_result_collector.sv
// conv_result_collector: tags convolution results with row/col/last, optional ReLU, buffers them in a show-ahead FIFO
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    synchronous flush of FIFO, coordinates and overflow
//   in_valid, in_data        one-cycle strobe carrying a signed convolution sum
//   out_valid, out_ready     valid/ready handshake on the FIFO head
//   out_data, out_row,
//   out_col, out_last        head entry (zero while out_valid=0)
//   frame_done               pulse the cycle after the last-of-frame entry is popped
//   overflow                 sticky flag: a strobe was dropped on a full FIFO
//   count                    FIFO occupancy
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module conv_result_collector #(
    parameter int OUT_DIM    = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int RELU_EN    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic signed [`DATA_WIDTH-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [`DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(OUT_DIM)-1:0]    out_row,
    output logic [$clog2(OUT_DIM)-1:0]    out_col,
    output logic                          out_last,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int DW   = `DATA_WIDTH;
    localparam int CW   = $clog2(OUT_DIM);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    typedef logic signed [DW-1:0] data_t;
    data_t                 mem_data_q [FIFO_DEPTH];
    logic [CW-1:0]         mem_row_q  [FIFO_DEPTH];
    logic [CW-1:0]         mem_col_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_q;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic [CW-1:0]         wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic                  overflow_q, overflow_d, frame_done_q, frame_done_d;
    logic                  pop, push, wr_last, col_end;
    data_t                 relu_data;

    always_comb begin
        // clear suppresses both handshakes so a strobe in the clear cycle is silently discarded
        pop          = !clear && count_q != '0 && out_ready;
        push         = !clear && in_valid && (count_q != CNTW'(FIFO_DEPTH) || pop);
        col_end      = wr_col_q == CW'(OUT_DIM - 1);
        wr_last      = col_end && wr_row_q == CW'(OUT_DIM - 1);
        relu_data    = (RELU_EN != 0 && in_data[DW-1]) ? '0 : in_data;
        wr_ptr_d     = clear ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = clear ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = clear ? '0 : count_q + CNTW'(push) - CNTW'(pop);
        overflow_d   = !clear && (overflow_q || (in_valid && !push));
        frame_done_d = pop && mem_last_q[rd_ptr_q];
        wr_col_d     = clear ? '0 : !push ? wr_col_q : col_end ? '0 : wr_col_q + CW'(1);
        wr_row_d     = clear ? '0 : !push ? wr_row_q : wr_last ? '0 : col_end ? wr_row_q + CW'(1) : wr_row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= relu_data;
            mem_row_q[wr_ptr_q]  <= wr_row_q;
            mem_col_q[wr_ptr_q]  <= wr_col_q;
            mem_last_q[wr_ptr_q] <= wr_last;
        end
    end

    always_comb begin
        out_valid  = count_q != '0;
        out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
        out_row    = out_valid ? mem_row_q[rd_ptr_q] : '0;
        out_col    = out_valid ? mem_col_q[rd_ptr_q] : '0;
        out_last   = out_valid && mem_last_q[rd_ptr_q];
        frame_done = frame_done_q;
        overflow   = overflow_q;
        count      = count_q;
    end
endmodule

// File: tb/tb_conv_result_collector.sv
// tb_conv_result_collector: directed checks of two collector configurations
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
module tb_conv_result_collector;
    logic clk, rst;
    logic a_clear, a_v, a_rdy, a_ov, a_last, a_fd, a_of;
    logic signed [15:0] a_d;
    logic [15:0] a_od;
    logic [0:0] a_row, a_col;
    logic [2:0] a_cnt;
    logic b_clear, b_v, b_rdy, b_ov, b_last, b_fd, b_of;
    logic signed [15:0] b_d;
    logic [15:0] b_od;
    logic [3:0] b_row, b_col;
    logic [2:0] b_cnt;
    int checks = 0;
    int failures = 0;

    conv_result_collector #(.OUT_DIM(2), .FIFO_DEPTH(4), .RELU_EN(1)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .in_valid(a_v), .in_data(a_d),
        .out_valid(a_ov), .out_ready(a_rdy), .out_data(a_od), .out_row(a_row),
        .out_col(a_col), .out_last(a_last), .frame_done(a_fd), .overflow(a_of), .count(a_cnt)
    );
    conv_result_collector #(.OUT_DIM(14), .FIFO_DEPTH(4), .RELU_EN(0)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .in_valid(b_v), .in_data(b_d),
        .out_valid(b_ov), .out_ready(b_rdy), .out_data(b_od), .out_row(b_row),
        .out_col(b_col), .out_last(b_last), .frame_done(b_fd), .overflow(b_of), .count(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {a_clear, a_v, a_rdy, b_clear, b_v, b_rdy} = '0;
        a_d = '0;
        b_d = '0;
        repeat (2) tick();
        chk("rst_a_valid", 32'(a_ov), 0);
        chk("rst_a_data", 32'(a_od), 0);
        chk("rst_a_rowcol", {a_row, a_col, a_last}, 0);
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_flags", {a_fd, a_of}, 0);
        chk("rst_b_valid", 32'(b_ov), 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        rst = 1'b0;
        tick();
        // frame of four results through a 2x2 map with ReLU and a ready consumer
        a_rdy = 1'b1;
        a_v = 1'b1;
        a_d = 16'sd5;
        tick();
        chk("t1_h0_valid", 32'(a_ov), 1);
        chk("t1_h0", {a_od, 1'(a_row), 1'(a_col), a_last}, {16'd5, 3'b000});
        chk("t1_h0_cnt", 32'(a_cnt), 1);
        a_d = -16'sd3;
        tick();
        chk("t1_h1", {a_od, 1'(a_row), 1'(a_col), a_last}, {16'd0, 3'b010});
        a_d = 16'sd7;
        tick();
        chk("t1_h2", {a_od, 1'(a_row), 1'(a_col), a_last}, {16'd7, 3'b100});
        a_d = 16'sd9;
        tick();
        chk("t1_h3", {a_od, 1'(a_row), 1'(a_col), a_last}, {16'd9, 3'b111});
        chk("t1_fd_early", 32'(a_fd), 0);
        a_v = 1'b0;
        tick();
        chk("t1_empty", 32'(a_ov), 0);
        chk("t1_cnt", 32'(a_cnt), 0);
        chk("t1_fd_pulse", 32'(a_fd), 1);
        tick();
        chk("t1_fd_low", 32'(a_fd), 0);
        chk("t1_overflow", 32'(a_of), 0);
        // ReLU boundaries
        a_v = 1'b1;
        a_d = 16'sh8000;
        tick();
        chk("t4_min_neg", 32'(a_od), 0);
        a_d = 16'sh7FFF;
        tick();
        chk("t4_max_pos", 32'(a_od), 32'h7FFF);
        a_v = 1'b0;
        tick();
        chk("t4_drained", 32'(a_ov), 0);
        // overflow on a stalled consumer
        for (int i = 1; i <= 5; i++) begin
            b_v = 1'b1;
            b_d = 16'(i);
            tick();
            chk($sformatf("t2_cnt%0d", i), 32'(b_cnt), (i < 4) ? i : 4);
            chk($sformatf("t2_of%0d", i), 32'(b_of), (i == 5) ? 1 : 0);
        end
        b_v = 1'b0;
        chk("t2_head1", {b_od, b_row, b_col}, {16'd1, 8'h00});
        b_rdy = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk($sformatf("t2_head%0d", i), {b_od, b_row, b_col}, {16'(i), 4'd0, 4'(i - 1)});
        end
        tick();
        chk("t2_no5", 32'(b_ov), 0);
        chk("t2_of_sticky", 32'(b_of), 1);
        b_rdy = 1'b0;
        b_clear = 1'b1;
        tick();
        b_clear = 1'b0;
        chk("clr_b_of", 32'(b_of), 0);
        // push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) begin
            b_v = 1'b1;
            b_d = 16'(20 + i);
            tick();
        end
        chk("t3_full", 32'(b_cnt), 4);
        b_rdy = 1'b1;
        b_d = 16'sd8;
        tick();
        b_v = 1'b0;
        chk("t3_cnt", 32'(b_cnt), 4);
        chk("t3_of", 32'(b_of), 0);
        chk("t3_head21", 32'(b_od), 21);
        tick();
        chk("t3_head22", 32'(b_od), 22);
        tick();
        chk("t3_head23", 32'(b_od), 23);
        tick();
        chk("t3_head8", {b_od, b_row, b_col}, {16'd8, 4'd0, 4'd4});
        tick();
        chk("t3_empty", 32'(b_ov), 0);
        // pass-through of negative values without ReLU
        b_v = 1'b1;
        b_d = -16'sd1;
        tick();
        b_v = 1'b0;
        chk("t4_noclamp", 32'(b_od), 32'hFFFF);
        // clear with a simultaneous strobe mid-frame
        a_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_v = 1'b1;
            a_d = 16'(10 + i);
            tick();
        end
        chk("t5_cnt3", 32'(a_cnt), 3);
        a_clear = 1'b1;
        a_d = 16'sd13;
        tick();
        a_clear = 1'b0;
        a_v = 1'b0;
        chk("t5_cnt", 32'(a_cnt), 0);
        chk("t5_valid", 32'(a_ov), 0);
        chk("t5_flags", {a_fd, a_of}, 0);
        a_v = 1'b1;
        a_d = 16'sd14;
        tick();
        chk("t5_tag", {a_od, 1'(a_row), 1'(a_col)}, {16'd14, 2'b00});
        a_d = 16'sd15;
        tick();
        a_v = 1'b0;
        chk("t6_pre_cnt", 32'(a_cnt), 2);
        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("t6_a_valid", 32'(a_ov), 0);
        chk("t6_a_cnt", 32'(a_cnt), 0);
        chk("t6_a_data", 32'(a_od), 0);
        chk("t6_b_valid", 32'(b_ov), 0);
        #2;
        rst = 1'b0;
        tick();
        a_v = 1'b1;
        a_d = 16'sd20;
        tick();
        a_v = 1'b0;
        chk("t6_tag", {a_od, 1'(a_row), 1'(a_col)}, {16'd20, 2'b00});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_result_collector.md
Name: conv_result_collector

Overview:
Downstream stage of the convolution engine. Captures each finished convolution sum, presented as a one-cycle strobe plus data word, and optionally applies ReLU. Tags each result with its output-feature-map row/column and last-of-frame flag, then buffers it in a small FIFO. The FIFO drains through a valid/ready stream toward the output writer, so a stalled consumer never stalls the convolution engine; overruns are flagged instead.

Parameters:
OUT_DIM, 14, output feature-map edge length (MATRIX_DIM-CONV_DIM+1); results per frame = OUT_DIM*OUT_DIM
FIFO_DEPTH, 4, result buffer entries; power of two, >=2
RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass through unchanged

Ports:
clk  in  1  system clock
rst  in  1  reset
clear  in  1  synchronous flush: empties FIFO, zeroes coordinates, clears overflow
in_valid  in  1  one-cycle strobe: in_data holds a completed convolution sum
in_data  in  `DATA_WIDTH (data_t)  signed convolution sum
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head this cycle
out_data  out  `DATA_WIDTH  result after optional ReLU
out_row  out  $clog2(OUT_DIM)  row of head result
out_col  out  $clog2(OUT_DIM)  column of head result
out_last  out  1  head is the final result of the frame (row=col=OUT_DIM-1)
frame_done  out  1  one-cycle pulse when the last-of-frame entry is popped
overflow  out  1  sticky: a strobe was dropped because the FIFO was full
count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Single clock domain, clock clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_row=0, out_col=0, out_last=0, frame_done=0, overflow=0, count=0. The write coordinate (wr_row, wr_col) resets to 0,0.
- Push occurs when in_valid=1 and (count<FIFO_DEPTH, or a pop happens in the same cycle). The entry stored is {relu(in_data), wr_row, wr_col, last}, where last=(wr_row==OUT_DIM-1 && wr_col==OUT_DIM-1).
- ReLU: if RELU_EN and in_data is negative (two's complement), store 0; otherwise store in_data unchanged. No width growth.
- Coordinate advance happens only on an accepted push:
  - wr_col increments.
  - At wr_col==OUT_DIM-1, wr_col wraps to 0 and wr_row increments.
  - At the last position, both wrap to 0 for the next frame.
- Pop occurs when out_valid && out_ready. FIFO is show-ahead: out_data, out_row, out_col and out_last reflect the head combinationally from registered storage, and are valid only while out_valid=1.
- Latency: push at edge N into an empty FIFO gives out_valid=1 after edge N; there is no bypass of in_data to out_data.
- Full case: if in_valid=1, count==FIFO_DEPTH and there is no pop, the strobe is dropped. overflow is set and stays 1 until clear or rst. Coordinates do not advance, so later results are mis-tagged until clear; this is intended, and software treats overflow as frame-fatal.
- Simultaneous push+pop when full: both succeed and count is unchanged.
- Simultaneous push+pop when empty: no pop occurs (out_valid=0); the push succeeds and count becomes 1.
- frame_done is registered: it is 1 in the cycle after a pop whose entry had last=1, and 0 otherwise.
- clear takes priority over push and pop in the same cycle. It empties the FIFO, zeroes the coordinates and clears overflow; frame_done is 0 in the next cycle. Any strobe arriving in the clear cycle is discarded without setting overflow.
- Asserting rst mid-frame discards all buffered results immediately.
- out_ready while out_valid=0 has no effect.
- Pointer wrap uses a natural power-of-two rollover. count is tracked explicitly, since full and empty differ even when pointers are equal.

Test Plan:
1. OUT_DIM=2, RELU_EN=1, out_ready=1; strobe 5, -3, 7, 9 on separate cycles -> outputs (5,r0,c0), (0,r0,c1), (7,r1,c0), (9,r1,c1,last=1); frame_done pulses once, one cycle after the final pop; overflow=0.
2. FIFO_DEPTH=4, out_ready=0; 5 strobes with values 1..5 -> count=4, overflow=1 after the 5th. Then out_ready=1 drains 1,2,3,4 with coordinates (0,0),(0,1),(0,2),(0,3); value 5 is never seen.
3. FIFO full, out_ready=1, in_valid=1 in the same cycle with value 8 -> head popped, 8 appended, count stays 4, overflow stays 0.
4. RELU_EN=0; strobe -1 (all ones) -> out_data is all ones. With RELU_EN=1, strobe the most-negative value -> 0, and +max passes through unchanged.
5. OUT_DIM=2; three strobes are pushed, then clear is asserted with in_valid=1 -> count=0, out_valid=0, overflow=0. The next strobe is tagged (0,0).
6. rst asserted asynchronously mid-frame between clock edges -> all outputs drop to reset values immediately; after release, the first result is tagged (0,0).
